// File: rtl/immgen_pipe.sv
// ID-stage immediate generator: decodes the RV32I/RV64I immediate (plus CSR zimm)
// from a raw instruction and presents it through a registered valid/ready stage.
module immgen_pipe #(
  parameter int unsigned XLEN = 32,
  parameter int unsigned SKID = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     instr,
  input  logic [2:0]      imm_sel,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] imm,
  output logic            imm_illegal
);

  localparam int unsigned W_EXT = 64;

  localparam logic [2:0] SEL_I     = 3'd0;
  localparam logic [2:0] SEL_S     = 3'd1;
  localparam logic [2:0] SEL_B     = 3'd2;
  localparam logic [2:0] SEL_U     = 3'd3;
  localparam logic [2:0] SEL_J     = 3'd4;
  localparam logic [2:0] SEL_SHAMT = 3'd5;
  localparam logic [2:0] SEL_ZIMM  = 3'd6;

  logic             w_s;
  logic [W_EXT-1:0] w_imm64;
  logic [XLEN-1:0]  w_imm;
  logic             w_illegal;
  logic             w_accept;
  logic             w_xfer;

  logic             r_out_valid;
  logic [XLEN-1:0]  r_imm;
  logic             r_illegal;
  logic             r_skid_valid;
  logic [XLEN-1:0]  r_skid_imm;
  logic             r_skid_illegal;

  assign w_s = instr[31];

  // Decode at 64 bits then truncate, so U-type sign bits fall away on XLEN=32.
  always_comb begin
    w_imm64   = '0;
    w_illegal = 1'b0;
    case (imm_sel)
      SEL_I:     w_imm64 = {{52{w_s}}, instr[31:20]};
      SEL_S:     w_imm64 = {{52{w_s}}, instr[31:25], instr[11:7]};
      SEL_B:     w_imm64 = {{52{w_s}}, instr[7], instr[30:25], instr[11:8], 1'b0};
      SEL_U:     w_imm64 = {{32{w_s}}, instr[31:12], 12'b0};
      SEL_J:     w_imm64 = {{44{w_s}}, instr[19:12], instr[20], instr[30:21], 1'b0};
      SEL_SHAMT: w_imm64 = (XLEN == 32) ? {59'b0, instr[24:20]} : {58'b0, instr[25:20]};
      SEL_ZIMM:  w_imm64 = {59'b0, instr[19:15]};
      default:   w_illegal = 1'b1;
    endcase
  end

  assign w_imm = w_imm64[XLEN-1:0];

  generate
    if (SKID != 0) begin : g_ready_skid
      assign in_ready = ~r_skid_valid;
    end else begin : g_ready_single
      assign in_ready = ~r_out_valid | out_ready;
    end
  endgenerate

  assign w_accept = in_valid & in_ready & ~flush;
  assign w_xfer   = r_out_valid & out_ready;

  // Main + skid storage; skid only ever fills behind a stalled main entry.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_valid    <= 1'b0;
      r_imm          <= '0;
      r_illegal      <= 1'b0;
      r_skid_valid   <= 1'b0;
      r_skid_imm     <= '0;
      r_skid_illegal <= 1'b0;
    end else if (flush) begin
      r_out_valid  <= 1'b0;
      r_skid_valid <= 1'b0;
    end else if (SKID != 0 && r_skid_valid) begin
      if (w_xfer) begin
        r_imm        <= r_skid_imm;
        r_illegal    <= r_skid_illegal;
        r_skid_valid <= 1'b0;
      end
    end else if (w_accept) begin
      if (!r_out_valid || w_xfer) begin
        r_out_valid <= 1'b1;
        r_imm       <= w_imm;
        r_illegal   <= w_illegal;
      end else if (SKID != 0) begin
        r_skid_valid   <= 1'b1;
        r_skid_imm     <= w_imm;
        r_skid_illegal <= w_illegal;
      end
    end else if (w_xfer) begin
      r_out_valid <= 1'b0;
    end
  end

  assign out_valid   = r_out_valid;
  assign imm         = r_imm;
  assign imm_illegal = r_illegal;

endmodule

// File: tb/tb_immgen_pipe.sv
// Directed bench for immgen_pipe: XLEN=32 and XLEN=64 with skid, plus XLEN=32 without.
module tb_immgen_pipe;

  logic        clk;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic [31:0] instr;
  logic [2:0]  imm_sel;
  logic        out_ready;

  logic        a_in_ready, a_out_valid, a_illegal;
  logic [31:0] a_imm;
  logic        b_in_ready, b_out_valid, b_illegal;
  logic [63:0] b_imm;
  logic        c_in_ready, c_out_valid, c_illegal;
  logic [31:0] c_imm;

  int n_cmp;
  int n_err;

  immgen_pipe #(.XLEN(32), .SKID(1)) u_a (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(a_in_ready),
    .instr(instr), .imm_sel(imm_sel), .out_valid(a_out_valid), .out_ready(out_ready),
    .imm(a_imm), .imm_illegal(a_illegal));

  immgen_pipe #(.XLEN(64), .SKID(1)) u_b (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(b_in_ready),
    .instr(instr), .imm_sel(imm_sel), .out_valid(b_out_valid), .out_ready(out_ready),
    .imm(b_imm), .imm_illegal(b_illegal));

  immgen_pipe #(.XLEN(32), .SKID(0)) u_c (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(c_in_ready),
    .instr(instr), .imm_sel(imm_sel), .out_valid(c_out_valid), .out_ready(out_ready),
    .imm(c_imm), .imm_illegal(c_illegal));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] ins, input logic [2:0] sel);
    in_valid = v;
    instr    = ins;
    imm_sel  = sel;
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst = 1'b1; flush = 1'b0; out_ready = 1'b1;
    drive(1'b0, 32'h0, 3'd0);
    tick();
    rst = 1'b0;
    chk("rst_valid",   64'(a_out_valid), 64'd0);
    chk("rst_imm",     64'(a_imm),       64'd0);
    chk("rst_illegal", 64'(a_illegal),   64'd0);
    chk("rst_ready",   64'(a_in_ready),  64'd1);
    chk("rst_ready_c", 64'(c_in_ready),  64'd1);

    // Decode across formats
    drive(1'b1, 32'hFFF00093, 3'd0); tick();
    chk("i_valid",   64'(a_out_valid), 64'd1);
    chk("i_imm32",   64'(a_imm),       64'h0000_0000_FFFF_FFFF);
    chk("i_illegal", 64'(a_illegal),   64'd0);
    chk("i_imm64",   b_imm,            64'hFFFF_FFFF_FFFF_FFFF);
    chk("i_imm_c",   64'(c_imm),       64'h0000_0000_FFFF_FFFF);
    drive(1'b1, 32'hFFDFF0EF, 3'd4); tick();
    chk("j_imm32", 64'(a_imm), 64'h0000_0000_FFFF_FFFC);
    chk("j_imm64", b_imm,      64'hFFFF_FFFF_FFFF_FFFC);
    drive(1'b1, 32'h00000463, 3'd2); tick();
    chk("b_imm32", 64'(a_imm), 64'd8);
    chk("b_imm64", b_imm,      64'd8);
    drive(1'b1, 32'hFE112E23, 3'd1); tick();
    chk("s_imm32", 64'(a_imm), 64'h0000_0000_FFFF_FFFC);
    chk("s_imm64", b_imm,      64'hFFFF_FFFF_FFFF_FFFC);
    drive(1'b1, 32'h800000B7, 3'd3); tick();
    chk("u_imm32", 64'(a_imm), 64'h0000_0000_8000_0000);
    chk("u_imm64", b_imm,      64'hFFFF_FFFF_8000_0000);
    drive(1'b1, 32'h03F09093, 3'd5); tick();
    chk("sh_imm32", 64'(a_imm), 64'd31);
    chk("sh_imm64", b_imm,      64'd63);
    drive(1'b1, 32'h03F09093, 3'd7); tick();
    chk("ill_imm32", 64'(a_imm),     64'd0);
    chk("ill_flag",  64'(a_illegal), 64'd1);
    chk("ill_imm64", b_imm,          64'd0);
    chk("ill_flag64", 64'(b_illegal), 64'd1);
    drive(1'b1, 32'h800FD073, 3'd6); tick();
    chk("zimm_imm32", 64'(a_imm),     64'd31);
    chk("zimm_ill",   64'(a_illegal), 64'd0);
    chk("zimm_imm64", b_imm,          64'd31);
    drive(1'b0, 32'h0, 3'd0); tick();
    chk("idle_valid", 64'(a_out_valid), 64'd0);
    chk("idle_hold",  64'(a_imm),       64'd31);

    // Backpressure: two entries fill main and skid, third is held
    out_ready = 1'b0;
    drive(1'b1, 32'h00100093, 3'd0);
    chk("bp_ready0", 64'(a_in_ready), 64'd1);
    tick();
    chk("bp_imm1", 64'(a_imm), 64'd1);
    chk("bp_ready1", 64'(a_in_ready), 64'd1);
    chk("bp_ready1_c", 64'(c_in_ready), 64'd0);
    drive(1'b1, 32'h00200093, 3'd0); tick();
    chk("bp_ready2", 64'(a_in_ready), 64'd0);
    chk("bp_hold1",  64'(a_imm),      64'd1);
    drive(1'b1, 32'h00300093, 3'd0); tick();
    chk("bp_ready3", 64'(a_in_ready),  64'd0);
    chk("bp_hold2",  64'(a_imm),       64'd1);
    chk("bp_valid",  64'(a_out_valid), 64'd1);
    chk("bp_hold_c", 64'(c_imm),       64'd1);
    out_ready = 1'b1; tick();
    chk("drain_imm2",   64'(a_imm),      64'd2);
    chk("drain_ready",  64'(a_in_ready), 64'd1);
    chk("drain_imm2_64", b_imm,          64'd2);
    chk("drain_c",      64'(c_imm),      64'd3);
    tick();
    chk("drain_imm3",   64'(a_imm),       64'd3);
    chk("drain_valid3", 64'(a_out_valid), 64'd1);
    drive(1'b0, 32'h0, 3'd0); tick();
    chk("drain_empty", 64'(a_out_valid), 64'd0);

    // Flush with main and skid both full and a new input offered
    out_ready = 1'b0;
    drive(1'b1, 32'h00A00093, 3'd0); tick();
    drive(1'b1, 32'h00B00093, 3'd0); tick();
    chk("fl_full", 64'(a_in_ready), 64'd0);
    flush = 1'b1;
    drive(1'b1, 32'h00C00093, 3'd0); tick();
    flush = 1'b0;
    drive(1'b0, 32'h0, 3'd0);
    chk("fl_valid",   64'(a_out_valid), 64'd0);
    chk("fl_ready",   64'(a_in_ready),  64'd1);
    chk("fl_valid64", 64'(b_out_valid), 64'd0);
    out_ready = 1'b1; tick();
    chk("fl_none", 64'(a_out_valid), 64'd0);
    drive(1'b1, 32'h00D00093, 3'd0); tick();
    chk("fl_next_v", 64'(a_out_valid), 64'd1);
    chk("fl_next",   64'(a_imm),       64'd13);
    flush = 1'b1;
    drive(1'b1, 32'h00E00093, 3'd0); tick();
    flush = 1'b0;
    drive(1'b0, 32'h0, 3'd0);
    chk("fl_drop_v",   64'(a_out_valid), 64'd0);
    chk("fl_drop_c",   64'(c_out_valid), 64'd0);
    tick();
    chk("fl_drop_v2",  64'(a_out_valid), 64'd0);

    // Reset while stalled with both entries valid
    out_ready = 1'b0;
    drive(1'b1, 32'h7FF00093, 3'd0); tick();
    drive(1'b1, 32'h00000000, 3'd7); tick();
    chk("rs_full", 64'(a_in_ready), 64'd0);
    rst = 1'b1; flush = 1'b1;
    drive(1'b1, 32'h00600093, 3'd0); tick();
    rst = 1'b0; flush = 1'b0;
    drive(1'b0, 32'h0, 3'd0);
    chk("rs_valid",   64'(a_out_valid), 64'd0);
    chk("rs_imm",     64'(a_imm),       64'd0);
    chk("rs_illegal", 64'(a_illegal),   64'd0);
    chk("rs_ready",   64'(a_in_ready),  64'd1);
    chk("rs_imm64",   b_imm,            64'd0);
    out_ready = 1'b1;
    drive(1'b1, 32'h00500093, 3'd0); tick();
    chk("rs_post_v", 64'(a_out_valid), 64'd1);
    chk("rs_post",   64'(a_imm),       64'd5);
    drive(1'b0, 32'h0, 3'd0); tick();
    chk("rs_end", 64'(a_out_valid), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
